// File: rtl/adpll_loop_ctrl_if.sv
// Interface between the ADPLL loop controller and its surroundings.
// It carries the divide ratio and PFD flags in, and the DCO code and lock status out.
interface adpll_loop_ctrl_if #(
  parameter int unsigned CODE_W = 8,
  parameter int unsigned M_W    = 3
);
  logic [M_W-1:0]    M;
  logic              p_up;
  logic              p_down;
  logic [CODE_W-1:0] dco_code;
  logic              freq_lock;
  logic              phase_lock;
  logic              polarity;

  modport master (output M, p_up, p_down,
                  input  dco_code, freq_lock, phase_lock, polarity);
  modport slave  (input  M, p_up, p_down,
                  output dco_code, freq_lock, phase_lock, polarity);
endinterface

// File: rtl/adpll_loop_ctrl.sv
// ADPLL loop controller: binary-search acquisition, then +/-1 phase tracking with lock and relock detection.
// Optional macro ADPLL_DEADBAND_EN ignores isolated PFD errors while LOCKED.
module adpll_loop_ctrl #(
  parameter int unsigned CODE_W     = 8,
  parameter int unsigned M_W        = 3,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned RELOCK_CNT = 8
) (
  input logic              clk,
  input logic              R_reset,
  adpll_loop_ctrl_if.slave bus
);
  localparam int unsigned SW = CODE_W - 1;
  localparam int unsigned QW = $clog2(LOCK_CNT + 1);
  localparam int unsigned RW = $clog2(RELOCK_CNT + 1);

  localparam logic [CODE_W-1:0] CODE_INIT = {1'b1, {(CODE_W-1){1'b0}}};
  localparam logic [SW-1:0]     STEP_INIT = {1'b1, {(SW-1){1'b0}}};

  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_TRACK  = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  logic [1:0]        state_q, state_n;
  logic [CODE_W-1:0] code_q, code_n;
  logic [SW-1:0]     step_q, step_n;
  logic              have_dir_q, have_dir_n;
  logic              freq_lock_q, freq_lock_n;
  logic              phase_lock_q, phase_lock_n;
  logic              polarity_q, polarity_n;
  logic [QW-1:0]     quiet_q, quiet_n;
  logic [RW-1:0]     run_q, run_n;
  logic [M_W-1:0]    m_q, m_n;
`ifdef ADPLL_DEADBAND_EN
  logic [1:0]        prev_err_q, prev_err_n;
`endif

  logic          is_up, is_dn, act, reversal, repeat_dir;
  logic          relock, db_hold, db_pair;
  logic [SW-1:0] step_half;
  logic [QW-1:0] quiet_inc;

  // Saturating add/subtract through a one-bit-wider intermediate.
  function automatic logic [CODE_W-1:0] adjust(input logic [CODE_W-1:0] code,
                                               input logic [SW-1:0]     amt,
                                               input logic              up);
    logic [CODE_W:0] wide;
    if (up) begin
      wide   = {1'b0, code} + (CODE_W+1)'(amt);
      adjust = wide[CODE_W] ? '1 : wide[CODE_W-1:0];
    end else begin
      wide   = {1'b0, code} - (CODE_W+1)'(amt);
      adjust = wide[CODE_W] ? '0 : wide[CODE_W-1:0];
    end
  endfunction

  always_comb begin
    state_n      = state_q;
    code_n       = code_q;
    step_n       = step_q;
    have_dir_n   = have_dir_q;
    freq_lock_n  = freq_lock_q;
    phase_lock_n = phase_lock_q;
    polarity_n   = polarity_q;
    quiet_n      = quiet_q;
    run_n        = run_q;
    m_n          = m_q;
    relock       = 1'b0;
    db_hold      = 1'b0;
    db_pair      = 1'b0;
    is_up        = bus.p_up & ~bus.p_down;
    is_dn        = bus.p_down & ~bus.p_up;
    act          = is_up | is_dn;
    reversal     = act & have_dir_q & (is_up != polarity_q);
    repeat_dir   = act & ~reversal & (run_q != '0);
    step_half    = ((step_q >> 1) == '0) ? SW'(1) : (step_q >> 1);
    quiet_inc    = (quiet_q == QW'(LOCK_CNT)) ? quiet_q : quiet_q + QW'(1);
`ifdef ADPLL_DEADBAND_EN
    prev_err_n   = {is_up, is_dn};
    if (state_q == S_LOCKED && act) begin
      if (prev_err_q == {is_up, is_dn}) db_pair = 1'b1;
      else                              db_hold = 1'b1;
    end
`endif

    if (bus.M != m_q) begin
      m_n    = bus.M;
      relock = 1'b1;
    end else if (state_q == S_SEARCH) begin
      if (act) begin
        code_n     = adjust(code_q, reversal ? step_half : step_q, is_up);
        polarity_n = is_up;
        have_dir_n = 1'b1;
        if (reversal) begin
          step_n = step_half;
          if (step_q == SW'(1)) begin
            freq_lock_n = 1'b1;
            state_n     = S_TRACK;
            quiet_n     = '0;
            run_n       = '0;
          end
        end
      end
    end else begin
      // TRACK and LOCKED share the +/-1 rules; deadband may suppress the step.
      if (act && !db_hold) begin
        code_n     = adjust(code_q, SW'(1), is_up);
        polarity_n = is_up;
        if (db_pair) begin
          quiet_n = '0;
          run_n   = RW'(1);
        end else if (reversal) begin
          quiet_n = quiet_inc;
          run_n   = RW'(1);
        end else begin
          run_n = run_q + RW'(1);
          if (run_q != '0) quiet_n = '0;
        end
      end else if (!act) begin
        quiet_n = quiet_inc;
        run_n   = '0;
      end
      if (run_n == RW'(RELOCK_CNT)) begin
        relock = 1'b1;
      end else if (state_q == S_TRACK && quiet_n == QW'(LOCK_CNT)) begin
        state_n      = S_LOCKED;
        phase_lock_n = 1'b1;
      end else if (state_q == S_LOCKED && ((repeat_dir && !db_hold) || db_pair)) begin
        state_n      = S_TRACK;
        phase_lock_n = 1'b0;
      end
    end

    // Restart acquisition from the current code.
    if (relock) begin
      state_n      = S_SEARCH;
      step_n       = STEP_INIT;
      have_dir_n   = 1'b0;
      freq_lock_n  = 1'b0;
      phase_lock_n = 1'b0;
      quiet_n      = '0;
      run_n        = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (R_reset) begin
      state_q      <= S_SEARCH;
      code_q       <= CODE_INIT;
      step_q       <= STEP_INIT;
      have_dir_q   <= 1'b0;
      freq_lock_q  <= 1'b0;
      phase_lock_q <= 1'b0;
      polarity_q   <= 1'b0;
      quiet_q      <= '0;
      run_q        <= '0;
      m_q          <= bus.M;
`ifdef ADPLL_DEADBAND_EN
      prev_err_q   <= 2'b00;
`endif
    end else begin
      state_q      <= state_n;
      code_q       <= code_n;
      step_q       <= step_n;
      have_dir_q   <= have_dir_n;
      freq_lock_q  <= freq_lock_n;
      phase_lock_q <= phase_lock_n;
      polarity_q   <= polarity_n;
      quiet_q      <= quiet_n;
      run_q        <= run_n;
      m_q          <= m_n;
`ifdef ADPLL_DEADBAND_EN
      prev_err_q   <= prev_err_n;
`endif
    end
  end

  assign bus.dco_code   = code_q;
  assign bus.freq_lock  = freq_lock_q;
  assign bus.phase_lock = phase_lock_q;
  assign bus.polarity   = polarity_q;
endmodule
